// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : note_sequencer
//  Purpose  : Plays a programmable list of (note, duration) entries and drives
//             the note word consumed by the note decoder. Each entry is shown
//             for dur ticks, followed by GAP_TICKS silent ticks. Entries with
//             dur=0 are skipped after their one-cycle LOAD.
//  Ports    : clk      - system clock
//             rst_n    - synchronous reset, active low
//             wr_en    - write entry wr_addr with wr_note/wr_dur
//             wr_addr  - entry index
//             wr_note  - note code (0 = rest)
//             wr_dur   - duration in ticks (0 = skip)
//             seq_len  - entries to play, sampled on accepted start
//             loop     - wrap to entry 0 after last entry
//             start    - begin playback (IDLE only)
//             stop     - abort playback (beats start)
//             note     - {zeros, 7-bit code}
//             busy     - high in every state except IDLE
//             done     - one-cycle pulse at natural end of non-looping play
//             cur_idx  - index of entry currently loaded/playing
//  Revision : 1.0 - initial release
// ============================================================================
module note_sequencer #(
    parameter int NOTE_W    = 27,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int DUR_W     = 8,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [6:0]        wr_note,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    output logic [NOTE_W-1:0] note,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_idx
);

    // Prescaler spans 0..TICK_DIV-1; tick counter must hold both dur-1 and GAP_TICKS-1.
    localparam int c_pre_w  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_gap_w  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int c_tick_w = (DUR_W > c_gap_w) ? DUR_W : c_gap_w;

    localparam logic [c_pre_w-1:0]  c_pre_max  = c_pre_w'(TICK_DIV - 1);
    localparam logic [c_tick_w-1:0] c_gap_last = c_tick_w'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [ADDR_W:0]     c_depth    = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PLAY = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [6:0]          r_mem_note [DEPTH];
    logic [DUR_W-1:0]    r_mem_dur  [DEPTH];

    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W:0]     r_len;
    logic [6:0]          r_code;
    logic [DUR_W-1:0]    r_dur;
    logic [c_pre_w-1:0]  r_pre;
    logic [c_tick_w-1:0] r_tick;

    logic                w_start_ok;
    logic                w_pre_end;
    logic                w_play_end;
    logic                w_gap_end;
    logic                w_cnt_end;
    logic                w_has_next;
    logic                w_adv;
    logic [DUR_W-1:0]    w_ent_dur;

    assign w_start_ok = start && !stop && (seq_len != '0);
    assign w_ent_dur  = r_mem_dur[r_idx];
    assign w_pre_end  = (r_pre == c_pre_max);
    assign w_play_end = w_pre_end && (r_tick == (c_tick_w'(r_dur) - c_tick_w'(1)));
    assign w_gap_end  = w_pre_end && (r_tick == c_gap_last);
    assign w_cnt_end  = (r_state == S_PLAY) ? w_play_end : w_gap_end;
    assign w_has_next = (({1'b0, r_idx} + (ADDR_W + 1)'(1)) < r_len);

    // Entry storage: no reset, writable in any state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem_note[wr_addr] <= wr_note;
            r_mem_dur[wr_addr]  <= wr_dur;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_adv   = 1'b0;
        note    = '0;
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_DONE);
        cur_idx = r_idx;

        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_ent_dur == '0) begin
                    w_adv = 1'b1;
                end else begin
                    w_next = S_PLAY;
                end
            end
            S_PLAY: begin
                note = NOTE_W'(r_code);
                if (w_play_end) begin
                    if (GAP_TICKS == 0) begin
                        w_adv = 1'b1;
                    end else begin
                        w_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_adv = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        if (w_adv) begin
            w_next = (w_has_next || loop) ? S_LOAD : S_DONE;
        end

        if (stop) begin
            w_next = S_IDLE;
            w_adv  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_len  <= '0;
            r_code <= '0;
            r_dur  <= '0;
            r_pre  <= '0;
            r_tick <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_idx <= '0;
                        r_len <= (seq_len > c_depth) ? c_depth : seq_len;
                    end
                end
                S_LOAD: begin
                    // Entry is snapshotted here so later rewrites only affect its next play.
                    r_code <= r_mem_note[r_idx];
                    r_dur  <= w_ent_dur;
                    r_pre  <= '0;
                    r_tick <= '0;
                end
                S_PLAY, S_GAP: begin
                    if (w_pre_end) begin
                        r_pre  <= '0;
                        r_tick <= w_cnt_end ? '0 : r_tick + c_tick_w'(1);
                    end else begin
                        r_pre  <= r_pre + c_pre_w'(1);
                    end
                end
                default: begin
                end
            endcase

            // Index stays on the last entry when the sequence ends without looping.
            if (w_adv) begin
                if (w_has_next) begin
                    r_idx <= r_idx + ADDR_W'(1);
                end else if (loop) begin
                    r_idx <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire
